// File: rtl/vga_cmd_port_if.sv
// Host command bus plus video RAM port of vga_cmd_port.
// The master side drives the commands and returns VRAM read data; the slave is the command port itself.
interface vga_cmd_port_if;
  logic [7:0]  i_cmd;
  logic [11:0] i_cur_adr;
  logic [7:0]  i_port;
  logic        i_cs_h;
  logic        i_rl_wh;
  logic [7:0]  o_port;
  logic        o_ready_h;
  logic [11:0] o_vram_addr;
  logic [7:0]  o_vram_data;
  logic        o_vram_we;
  logic [7:0]  i_vram_q;
  logic [11:0] o_cursor_addr;
  logic        o_cursor_en;

  modport master (
    output i_cmd, i_cur_adr, i_port, i_cs_h, i_rl_wh, i_vram_q,
    input  o_port, o_ready_h, o_vram_addr, o_vram_data, o_vram_we,
           o_cursor_addr, o_cursor_en
  );

  modport slave (
    input  i_cmd, i_cur_adr, i_port, i_cs_h, i_rl_wh, i_vram_q,
    output o_port, o_ready_h, o_vram_addr, o_vram_data, o_vram_we,
           o_cursor_addr, o_cursor_en
  );
endinterface

// File: rtl/vga_cmd_port.sv
// Text-mode VGA command port: one command per rising edge of chip select, driving cursor and video RAM.
// Define VGA_CMD_CLS_EN to build in the clear-screen command (8'h04); otherwise it is treated as unknown.
module vga_cmd_port #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 25,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input logic           i_clk,
  input logic           i_rst,
  vga_cmd_port_if.slave bus
);

  localparam logic [11:0] CELLS = 12'(COLS * ROWS);
  localparam logic [11:0] LAST  = CELLS - 12'd1;

  typedef enum logic [2:0] {IDLE, EXEC, RD_WAIT, RD_LATCH, CLS, DONE} state_t;

  state_t      state, state_next;
  logic        cs_prev;
  logic        ready;
  logic        accept;
  logic [7:0]  cmd_q;
  logic [11:0] cur_adr_q;
  logic [7:0]  port_q;
  logic        rl_wh_q;
  logic [11:0] cursor;
  logic        cursor_en;
  logic [7:0]  rd_data;

  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        load_cursor;
  logic [11:0] cursor_next;
  logic        load_en;
  logic        en_next;
  logic        load_port;

  logic is_set, is_wr, is_rd, is_on, is_off;
  assign is_set = rl_wh_q  && (cmd_q == 8'h01);
  assign is_wr  = rl_wh_q  && (cmd_q == 8'h02);
  assign is_rd  = !rl_wh_q && (cmd_q == 8'h03);
  assign is_on  = rl_wh_q  && (cmd_q == 8'h05);
  assign is_off = rl_wh_q  && (cmd_q == 8'h06);

`ifdef VGA_CMD_CLS_EN
  logic        is_cls;
  logic        cls_start;
  logic [11:0] cls_cnt;
  assign is_cls = rl_wh_q && (cmd_q == 8'h04);
`endif

  // ready is only high in IDLE, so this also rejects edges that arrive while busy
  assign accept = bus.i_cs_h && !cs_prev && ready;

  always_comb begin
    state_next  = state;
    vram_we     = 1'b0;
    vram_addr   = 12'd0;
    vram_data   = 8'd0;
    load_cursor = 1'b0;
    cursor_next = cursor;
    load_en     = 1'b0;
    en_next     = cursor_en;
    load_port   = 1'b0;
`ifdef VGA_CMD_CLS_EN
    cls_start   = 1'b0;
`endif
    case (state)
      IDLE: if (accept) state_next = EXEC;
      EXEC: begin
        state_next = DONE;
        if (is_set) begin
          load_cursor = 1'b1;
          cursor_next = (cur_adr_q < CELLS) ? cur_adr_q : 12'd0;
        end else if (is_wr) begin
          vram_we     = 1'b1;
          vram_addr   = cursor;
          vram_data   = port_q;
          load_cursor = 1'b1;
          cursor_next = (cursor == LAST) ? 12'd0 : cursor + 12'd1;
        end else if (is_rd) begin
          vram_addr  = cursor;
          state_next = RD_WAIT;
        end else if (is_on) begin
          load_en = 1'b1;
          en_next = 1'b1;
        end else if (is_off) begin
          load_en = 1'b1;
          en_next = 1'b0;
        end
`ifdef VGA_CMD_CLS_EN
        else if (is_cls) begin
          cls_start  = 1'b1;
          state_next = CLS;
        end
`endif
      end
      // Address stays on the bus so the synchronous RAM output remains valid for the latch
      RD_WAIT: begin
        vram_addr  = cursor;
        state_next = RD_LATCH;
      end
      RD_LATCH: begin
        vram_addr  = cursor;
        load_port  = 1'b1;
        state_next = DONE;
      end
`ifdef VGA_CMD_CLS_EN
      CLS: begin
        vram_we   = 1'b1;
        vram_addr = cls_cnt;
        vram_data = FILL_CHAR;
        if (cls_cnt == LAST) begin
          load_cursor = 1'b1;
          cursor_next = 12'd0;
          state_next  = DONE;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cs_prev   <= 1'b1;
      ready     <= 1'b1;
      cmd_q     <= 8'd0;
      cur_adr_q <= 12'd0;
      port_q    <= 8'd0;
      rl_wh_q   <= 1'b0;
      cursor    <= 12'd0;
      cursor_en <= 1'b1;
      rd_data   <= 8'd0;
`ifdef VGA_CMD_CLS_EN
      cls_cnt   <= 12'd0;
`endif
    end else begin
      state   <= state_next;
      cs_prev <= bus.i_cs_h;
      if (accept) begin
        cmd_q     <= bus.i_cmd;
        cur_adr_q <= bus.i_cur_adr;
        port_q    <= bus.i_port;
        rl_wh_q   <= bus.i_rl_wh;
        ready     <= 1'b0;
      end else if (state == DONE) begin
        ready <= 1'b1;
      end
      if (load_cursor) cursor    <= cursor_next;
      if (load_en)     cursor_en <= en_next;
      if (load_port)   rd_data   <= bus.i_vram_q;
`ifdef VGA_CMD_CLS_EN
      if (cls_start)          cls_cnt <= 12'd0;
      else if (state == CLS)  cls_cnt <= cls_cnt + 12'd1;
`endif
    end
  end

  // Reset silences the RAM port immediately so an aborted clear issues no further writes
  assign bus.o_vram_we     = vram_we && !i_rst;
  assign bus.o_vram_addr   = i_rst ? 12'd0 : vram_addr;
  assign bus.o_vram_data   = i_rst ? 8'd0 : vram_data;
  assign bus.o_ready_h     = ready;
  assign bus.o_port        = rd_data;
  assign bus.o_cursor_addr = cursor;
  assign bus.o_cursor_en   = cursor_en;

endmodule

// File: tb/tb_vga_cmd_port.sv
// Bench for vga_cmd_port: directed steps plus random commands against a command-level model.
// A synchronous VRAM model answers reads one cycle after the address.
module tb_vga_cmd_port;

  localparam int         COLS  = 80;
  localparam int         ROWS  = 25;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] FILL  = 8'h20;

  logic clk = 1'b0;
  logic rst;

  vga_cmd_port_if bus ();

  vga_cmd_port #(.COLS(COLS), .ROWS(ROWS), .FILL_CHAR(FILL)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] vram [0:4095];
  always @(posedge clk) begin
    if (bus.o_vram_we) vram[bus.o_vram_addr] <= bus.o_vram_data;
    bus.i_vram_q <= vram[bus.o_vram_addr];
  end

  int          busy_cnt;
  logic [11:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  always @(negedge clk) begin
    if (!bus.o_ready_h) busy_cnt++;
    if (bus.o_vram_we) begin
      wr_addr_q.push_back(bus.o_vram_addr);
      wr_data_q.push_back(bus.o_vram_data);
    end
  end

  int checks   = 0;
  int failures = 0;

  int         m_cursor;
  logic       m_en;
  logic [7:0] m_port;
  logic [7:0] m_vram [0:4095];
  int         exp_busy;
  int         exp_addr_q[$];
  logic [7:0] exp_data_q[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what each command does to cursor, visibility, read data and screen memory
  task automatic model_exec(input logic [7:0] cmd, input logic [11:0] cur,
                            input logic [7:0] port, input logic rl_wh);
    exp_busy = 2;
    exp_addr_q.delete();
    exp_data_q.delete();
    if (rl_wh && cmd == 8'h01) begin
      m_cursor = (int'(cur) < CELLS) ? int'(cur) : 0;
    end else if (rl_wh && cmd == 8'h02) begin
      exp_addr_q.push_back(m_cursor);
      exp_data_q.push_back(port);
      m_vram[m_cursor] = port;
      m_cursor = (m_cursor + 1) % CELLS;
    end else if (!rl_wh && cmd == 8'h03) begin
      m_port   = m_vram[m_cursor];
      exp_busy = 4;
    end else if (rl_wh && cmd == 8'h05) begin
      m_en = 1'b1;
    end else if (rl_wh && cmd == 8'h06) begin
      m_en = 1'b0;
    end
`ifdef VGA_CMD_CLS_EN
    else if (rl_wh && cmd == 8'h04) begin
      for (int i = 0; i < CELLS; i++) begin
        exp_addr_q.push_back(i);
        exp_data_q.push_back(FILL);
        m_vram[i] = FILL;
      end
      m_cursor = 0;
      exp_busy = CELLS + 2;
    end
`endif
  endtask

  // One chip-select transaction; poke >= 0 raises chip select again that many cycles into the busy window
  task automatic apply_stimulus(input logic [7:0] cmd, input logic [11:0] cur,
                                input logic [7:0] port, input logic rl_wh, input int poke);
    int n;
    n = 0;
    while (!bus.o_ready_h && n < 100) begin tick(); n++; end
    busy_cnt = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.i_cmd     = cmd;
    bus.i_cur_adr = cur;
    bus.i_port    = port;
    bus.i_rl_wh   = rl_wh;
    bus.i_cs_h    = 1'b1;
    tick();
    bus.i_cs_h = 1'b0;
    n = 0;
    while (!bus.o_ready_h && n < CELLS + 100) begin
      if (n == poke) begin
        bus.i_cs_h  = 1'b1;
        bus.i_cmd   = 8'h02;
        bus.i_rl_wh = 1'b1;
      end
      tick();
      n++;
    end
    bus.i_cs_h = 1'b0;
    check_output("ready_timeout", 32'(n >= CELLS + 100), 0);
  endtask

  task automatic compare_all(input string tag);
    int bad;
    check_output({tag, ".busy"}, busy_cnt, exp_busy);
    check_output({tag, ".nwr"}, wr_addr_q.size(), exp_addr_q.size());
    if (wr_addr_q.size() == exp_addr_q.size() && exp_addr_q.size() > 0) begin
      check_output({tag, ".wr_addr0"}, wr_addr_q[0], exp_addr_q[0]);
      check_output({tag, ".wr_data0"}, wr_data_q[0], exp_data_q[0]);
      bad = -1;
      for (int i = exp_addr_q.size() - 1; i >= 0; i--)
        if (int'(wr_addr_q[i]) != exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) bad = i;
      check_output({tag, ".wr_first_bad"}, bad, -1);
    end
    check_output({tag, ".cursor"}, bus.o_cursor_addr, m_cursor);
    check_output({tag, ".cur_en"}, bus.o_cursor_en, m_en);
    check_output({tag, ".port"}, bus.o_port, m_port);
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] cmd, input logic [11:0] cur,
                               input logic [7:0] port, input logic rl_wh, input int poke);
    model_exec(cmd, cur, port, rl_wh);
    apply_stimulus(cmd, cur, port, rl_wh, poke);
    compare_all(tag);
  endtask

  initial begin
    logic [7:0]  c, p;
    logic [11:0] a;
    logic        w;
    int          kind, n;

    for (int i = 0; i < 4096; i++) begin
      vram[i]   = 8'h00;
      m_vram[i] = 8'h00;
    end
    vram[10]   = 8'h5A;
    m_vram[10] = 8'h5A;
    m_cursor = 0;
    m_en     = 1'b1;
    m_port   = 8'h00;

    // Reset with chip select already high: no transaction may start afterwards
    rst = 1'b1;
    bus.i_cs_h = 1'b1;
    bus.i_cmd = 8'h02; bus.i_cur_adr = 12'd0; bus.i_port = 8'hEE; bus.i_rl_wh = 1'b1;
    repeat (3) tick();
    check_output("rst.ready", bus.o_ready_h, 1);
    check_output("rst.cursor", bus.o_cursor_addr, 0);
    check_output("rst.cur_en", bus.o_cursor_en, 1);
    check_output("rst.port", bus.o_port, 0);
    check_output("rst.we", bus.o_vram_we, 0);
    check_output("rst.addr", bus.o_vram_addr, 0);
    check_output("rst.data", bus.o_vram_data, 0);
    rst = 1'b0;
    busy_cnt = 0;
    wr_addr_q.delete();
    repeat (4) tick();
    check_output("cs_high_thru_rst.busy", busy_cnt, 0);
    check_output("cs_high_thru_rst.nwr", wr_addr_q.size(), 0);
    bus.i_cs_h = 1'b0;
    tick();

    run_and_check("set100", 8'h01, 12'd100, 8'h00, 1'b1, -1);
    run_and_check("wr41", 8'h02, 12'd0, 8'h41, 1'b1, -1);
    run_and_check("set1999", 8'h01, 12'd1999, 8'h00, 1'b1, -1);
    run_and_check("wr42_wrap", 8'h02, 12'd0, 8'h42, 1'b1, -1);
    run_and_check("set100b", 8'h01, 12'd100, 8'h00, 1'b1, -1);
    run_and_check("set2500", 8'h01, 12'd2500, 8'h00, 1'b1, -1);
    run_and_check("set10", 8'h01, 12'd10, 8'h00, 1'b1, -1);
    run_and_check("rd10", 8'h03, 12'd0, 8'h00, 1'b0, -1);

    // Edge while busy must be dropped, not queued
    run_and_check("set20", 8'h01, 12'd20, 8'h00, 1'b1, -1);
    run_and_check("rd_busy_edge", 8'h03, 12'd0, 8'h00, 1'b0, 1);
    busy_cnt = 0;
    wr_addr_q.delete();
    repeat (4) tick();
    check_output("busy_edge_dropped.busy", busy_cnt, 0);
    check_output("busy_edge_dropped.nwr", wr_addr_q.size(), 0);

    run_and_check("wr_as_read", 8'h02, 12'd0, 8'h99, 1'b0, -1);
    run_and_check("cmd_ff", 8'hFF, 12'd5, 8'h99, 1'b1, -1);
    run_and_check("cur_off", 8'h06, 12'd0, 8'h00, 1'b1, -1);
    run_and_check("cur_on", 8'h05, 12'd0, 8'h00, 1'b1, -1);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 6);
      a = 12'($urandom_range(0, 4095));
      p = 8'($urandom);
      c = 8'h00;
      w = 1'b1;
      case (kind)
        0: begin
          c = 8'h01;
          if ($urandom_range(0, 1) == 1) a = 12'($urandom_range(1990, 1999));
        end
        1: c = 8'h02;
        2: begin c = 8'h03; w = 1'b0; end
        3: c = 8'h05;
        4: c = 8'h06;
        5: begin c = 8'($urandom_range(7, 255)); w = 1'($urandom_range(0, 1)); end
        default: begin c = 8'($urandom_range(1, 6)); w = (c == 8'h03); end
      endcase
      run_and_check($sformatf("rnd%0d_c%0h", i, c), c, a, p, w, -1);
    end

`ifdef VGA_CMD_CLS_EN
    run_and_check("cls_full", 8'h04, 12'd0, 8'h00, 1'b1, -1);
    run_and_check("set10c", 8'h01, 12'd10, 8'h00, 1'b1, -1);
    run_and_check("wr77", 8'h02, 12'd0, 8'h77, 1'b1, -1);
    run_and_check("set10d", 8'h01, 12'd10, 8'h00, 1'b1, -1);
    run_and_check("rd77", 8'h03, 12'd0, 8'h00, 1'b0, -1);
    run_and_check("cur_off2", 8'h06, 12'd0, 8'h00, 1'b1, -1);

    // Reset lands after 500 clear-screen writes; nothing may follow
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.i_cmd = 8'h04; bus.i_rl_wh = 1'b1; bus.i_cs_h = 1'b1;
    tick();
    bus.i_cs_h = 1'b0;
    n = 0;
    while (wr_addr_q.size() < 500 && n < 3000) begin tick(); n++; end
    check_output("cls_abort.timeout", 32'(n >= 3000), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("cls_abort.nwr_at_rst", wr_addr_q.size(), 500);
    wr_addr_q.delete();
    busy_cnt = 0;
    repeat (6) tick();
    m_cursor = 0; m_en = 1'b1; m_port = 8'h00;
    check_output("cls_abort.nwr_after", wr_addr_q.size(), 0);
    check_output("cls_abort.busy_after", busy_cnt, 0);
    check_output("cls_abort.ready", bus.o_ready_h, 1);
    check_output("cls_abort.cursor", bus.o_cursor_addr, m_cursor);
    check_output("cls_abort.cur_en", bus.o_cursor_en, m_en);
    check_output("cls_abort.port", bus.o_port, m_port);
`else
    run_and_check("cls_as_unknown", 8'h04, 12'd0, 8'h00, 1'b1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_cmd_port.md
VGA_CMD_PORT -- requirements
Module: vga_cmd_port

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per text row.
REQ-002 SHALL have parameter ROWS, default 25, text rows; CELLS = COLS*ROWS (2000 at defaults).
REQ-003 SHALL have parameter FILL_CHAR, default 8'h20, code written by clear-screen.
REQ-004 i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_cmd  input  8  command code, sampled at accept.
REQ-007 i_cur_adr  input  12  cursor address for SET_CUR, sampled at accept.
REQ-008 i_port  input  8  character data for WR_CHAR, sampled at accept.
REQ-009 o_port  output  8  character returned by RD_CHAR; held until the next RD_CHAR completes.
REQ-010 i_cs_h  input  1  chip select; a rising edge requests one transaction.
REQ-011 i_rl_wh  input  1  0 = read transaction, 1 = write transaction; sampled at accept.
REQ-012 o_ready_h  output  1  1 = idle and able to accept; 0 = busy.
REQ-013 o_vram_addr  output  12  video RAM address.
REQ-014 o_vram_data  output  8  video RAM write data.
REQ-015 o_vram_we  output  1  video RAM write strobe, one write per cycle high.
REQ-016 i_vram_q  input  8  video RAM read data, valid one cycle after address is presented.
REQ-017 o_cursor_addr  output  12  cursor position to the display path.
REQ-018 o_cursor_en  output  1  cursor visible.

Function
REQ-019 Accept SHALL occur on a clock where i_cs_h=1, i_cs_h on the previous clock=0, and o_ready_h=1; an edge while busy SHALL be ignored, not queued.
REQ-020 At accept, cmd/cur_adr/port/rl_wh SHALL be latched, o_ready_h SHALL go 0 on the next cycle, and FSM SHALL leave IDLE.
REQ-021 FSM states: IDLE, EXEC, RD_WAIT, RD_LATCH, CLS, DONE; DONE SHALL set o_ready_h=1 and return to IDLE.
REQ-022 Write commands (rl_wh=1): 8'h01 SET_CUR, 8'h02 WR_CHAR, 8'h04 CLS, 8'h05 CUR_ON, 8'h06 CUR_OFF; read command (rl_wh=0): 8'h03 RD_CHAR.
REQ-023 Unknown code or rl_wh not matching the command SHALL have no effect: IDLE->EXEC->DONE, o_ready_h low 2 cycles.
REQ-024 SET_CUR SHALL load cursor with cur_adr if cur_adr < CELLS, else with 0; o_ready_h low 2 cycles.
REQ-025 WR_CHAR SHALL drive o_vram_we=1 for exactly one cycle in EXEC with addr = cursor and data = port, then cursor+1, wrapping CELLS-1 -> 0; o_ready_h low 2 cycles.
REQ-026 RD_CHAR SHALL present addr = cursor in EXEC, wait in RD_WAIT, load o_port from i_vram_q in RD_LATCH; cursor unchanged; o_ready_h low 4 cycles.
REQ-027 CUR_ON/CUR_OFF SHALL set/clear o_cursor_en; o_ready_h low 2 cycles.
REQ-028 CLS SHALL write FILL_CHAR to addresses 0..CELLS-1 ascending, one per cycle, o_vram_we continuously high for CELLS cycles, then set cursor to 0; o_ready_h low CELLS+2 cycles.
REQ-029 o_vram_we SHALL be 0 in every state other than WR_CHAR EXEC and CLS.
REQ-030 Cursor and address arithmetic SHALL be 12-bit unsigned; cursor SHALL never hold a value >= CELLS.

Reset
REQ-031 i_rst=1 SHALL force: state IDLE, o_ready_h=1, o_port=0, o_vram_addr=0, o_vram_data=0, o_vram_we=0, o_cursor_addr=0, o_cursor_en=1.
REQ-032 The cs_h edge register SHALL reset to 1, so i_cs_h held high through reset SHALL NOT start a transaction.
REQ-033 Reset during any transaction, including mid-CLS, SHALL abort it at that clock with no further VRAM writes.

Configuration
REQ-034 Macro VGA_CMD_CLS_EN defined: CLS command and the CLS state SHALL exist as in REQ-028.
REQ-035 Macro VGA_CMD_CLS_EN undefined: CLS logic SHALL be omitted and 8'h04 SHALL be handled as unknown (REQ-023).

Verification
REQ-036 Reset, then SET_CUR cur_adr=12'd100, WR_CHAR port=8'h41 -> one we pulse addr=100 data=8'h41; o_cursor_addr=101; ready low 2 cycles each.
REQ-037 SET_CUR 12'd1999, WR_CHAR 8'h42 -> write at 1999, o_cursor_addr=0; SET_CUR 12'd2500 -> o_cursor_addr=0.
REQ-038 VRAM model holds 8'h5A at 10; SET_CUR 10, RD_CHAR (rl_wh=0) -> o_port=8'h5A, ready low 4 cycles, cursor stays 10.
REQ-039 CLS (macro defined) -> 2000 consecutive writes of 8'h20 to 0..1999, cursor 0, ready low 2002 cycles; i_rst pulse after 500 writes -> writes stop, o_ready_h=1.
REQ-040 cs_h edge while busy, WR_CHAR with rl_wh=0, cmd 8'hFF, and CUR_OFF -> first three: no VRAM write, no cursor change; CUR_OFF -> o_cursor_en=0.
